// File: rtl/cross_comm_param_loader.sv
// Cross-commodity parameter loader: parses framed byte records, checks checksum and inter-rate range,
// and presents a validated parameter set over valid/ready. Optional inter-byte timeout: CCL_TIMEOUT_EN.
module cross_comm_param_loader #(
  parameter logic [7:0]  SOF_BYTE       = 8'hA5,
  parameter int unsigned MAX_INTER_RATE = 100,
  parameter int unsigned ERR_CNT_W      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           in_byte,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [15:0]          outright_rate0,
  output logic [15:0]          outright_rate1,
  output logic [7:0]           ratio0,
  output logic [7:0]           ratio1,
  output logic [7:0]           inter_rate,
  output logic                 param_valid,
  input  logic                 param_ready,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PAYLOAD = 2'd1;
  localparam logic [1:0] CHECK   = 2'd2;
  localparam logic [1:0] HOLD    = 2'd3;

  localparam logic [7:0] MAX_IR = 8'(MAX_INTER_RATE);

  logic [1:0] state;
  logic [2:0] idx;
  logic [7:0] chk;
  logic [7:0] shadow [7];
  logic       accept;
  logic       frame_ok;
  logic       reject;
  logic       timeout;

  assign in_ready = (state != HOLD);
  assign accept   = in_valid && in_ready;

`ifdef CCL_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] idle_cnt;

  // Counts stalled cycles within a frame; the abort fires on the cycle the limit is reached.
  always_ff @(posedge clk) begin
    if (!reset || accept || !(state == PAYLOAD || state == CHECK))
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 16'd1;
  end

  assign timeout = (state == PAYLOAD || state == CHECK) && !accept && (idle_cnt == TO_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    frame_ok = 1'b0;
    reject   = timeout;
    if (state == CHECK && accept) begin
      frame_ok = (in_byte == chk) && (shadow[6] <= MAX_IR);
      reject   = !frame_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      idx            <= '0;
      chk            <= '0;
      for (int unsigned i = 0; i < 7; i++) shadow[i] <= '0;
      outright_rate0 <= '0;
      outright_rate1 <= '0;
      ratio0         <= '0;
      ratio1         <= '0;
      inter_rate     <= '0;
      param_valid    <= 1'b0;
      frame_err      <= 1'b0;
      err_count      <= '0;
    end else begin
      frame_err <= reject;
      if (reject) begin
        state <= IDLE;
        if (err_count != '1) err_count <= err_count + 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (accept && in_byte == SOF_BYTE) begin
              state <= PAYLOAD;
              idx   <= '0;
              chk   <= '0;
            end
          end
          PAYLOAD: begin
            if (accept) begin
              shadow[idx] <= in_byte;
              chk         <= chk ^ in_byte;
              if (idx == 3'd6) state <= CHECK;
              else             idx   <= idx + 3'd1;
            end
          end
          CHECK: begin
            if (frame_ok) begin
              outright_rate0 <= {shadow[0], shadow[1]};
              outright_rate1 <= {shadow[2], shadow[3]};
              ratio0         <= shadow[4];
              ratio1         <= shadow[5];
              inter_rate     <= shadow[6];
              param_valid    <= 1'b1;
              state          <= HOLD;
            end
          end
          default: begin
            if (param_ready) begin
              param_valid <= 1'b0;
              state       <= IDLE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cross_comm_param_loader.sv
// Scoreboard bench for cross_comm_param_loader: a frame-level model queues expected parameter sets
// and error events as the driver sends them; a negedge monitor pops and compares.
module tb_cross_comm_param_loader;
`ifdef CCL_TIMEOUT_EN
  localparam int unsigned TO = 20;
`else
  localparam int unsigned TO = 255;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] outright_rate0, outright_rate1;
  logic [7:0]  ratio0, ratio1, inter_rate;
  logic        param_valid;
  logic        param_ready;
  logic        frame_err;
  logic [7:0]  err_count;

  cross_comm_param_loader #(
    .SOF_BYTE(8'hA5), .MAX_INTER_RATE(100), .ERR_CNT_W(8), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .outright_rate0(outright_rate0), .outright_rate1(outright_rate1),
    .ratio0(ratio0), .ratio1(ratio1), .inter_rate(inter_rate),
    .param_valid(param_valid), .param_ready(param_ready),
    .frame_err(frame_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [55:0] p; logic [31:0] cyc; } pset_t;
  typedef struct packed { logic [7:0] cnt; logic [31:0] cyc; } err_t;

  pset_t       exp_q[$];
  err_t        err_q[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned err_m = 0;
  int unsigned ready_mode = 1;
  logic [31:0] cyc = '0;
  logic        rst_at_edge = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_event(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event with no expectation queued (cycle %0d)", name, cyc);
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 32'd1;
    rst_at_edge = !reset;
  end

  initial begin
    param_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       param_ready = 1'($urandom % 2);
        2:       param_ready = 1'b0;
        default: param_ready = 1'b1;
      endcase
    end
  end

  task automatic send_byte(input logic [7:0] b, output logic [31:0] acc_cyc);
    int unsigned t = 0;
    in_byte  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    check("in_ready_wait", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    in_byte  = 8'($urandom);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [55:0] pl, input logic [7:0] cs, input int unsigned maxgap);
    logic [31:0] c;
    logic [7:0]  x = '0;
    logic [7:0]  b;
    send_byte(8'hA5, c);
    idle($urandom_range(0, maxgap));
    for (int i = 0; i < 7; i++) begin
      b = pl[55-8*i -: 8];
      x ^= b;
      send_byte(b, c);
      idle($urandom_range(0, maxgap));
    end
    send_byte(cs, c);
    if (cs == x && pl[7:0] <= 8'd100) exp_q.push_back('{p: pl, cyc: c});
    else begin
      if (err_m != 255) err_m++;
      err_q.push_back('{cnt: 8'(err_m), cyc: c});
    end
  endtask

  function automatic logic [7:0] xsum(input logic [55:0] pl);
    logic [7:0] x = '0;
    for (int i = 0; i < 7; i++) x ^= pl[8*i +: 8];
    return x;
  endfunction

  // Monitor
  initial begin
    logic        pv_d = 1'b0, hs_d = 1'b0;
    logic [55:0] cur = '0;
    logic [7:0]  seen = '0;
    pset_t       e;
    err_t        ee;
    forever begin
      @(negedge clk);
      if (rst_at_edge) begin
        check("reset_params", 64'({outright_rate0, outright_rate1, ratio0, ratio1, inter_rate}), 64'd0);
        check("reset_flags", 64'({param_valid, frame_err, err_count, in_ready}), 64'h001);
        cur = '0; seen = '0; pv_d = 1'b0; hs_d = 1'b0;
      end else begin
        check("in_ready_vs_hold", 64'(in_ready), 64'(!param_valid));
        if (param_valid && !pv_d) begin
          if (exp_q.size() == 0) fail_event("unexpected_param_valid");
          else begin
            e = exp_q.pop_front();
            check("params", 64'({outright_rate0, outright_rate1, ratio0, ratio1, inter_rate}), 64'(e.p));
            check("param_latency", 64'(cyc), 64'(e.cyc));
            cur = e.p;
          end
        end
        if (hs_d)      check("pv_drop_after_handshake", 64'(param_valid), 64'd0);
        else if (pv_d) check("pv_held", 64'(param_valid), 64'd1);
        check("outputs_stable", 64'({outright_rate0, outright_rate1, ratio0, ratio1, inter_rate}), 64'(cur));
        if (frame_err) begin
          if (err_q.size() == 0) fail_event("unexpected_frame_err");
          else begin
            ee = err_q.pop_front();
            check("err_count_on_reject", 64'(err_count), 64'(ee.cnt));
            check("frame_err_latency", 64'(cyc), 64'(ee.cyc));
            seen = ee.cnt;
          end
        end
        check("err_count", 64'(err_count), 64'(seen));
        hs_d = param_valid && param_ready;
        pv_d = param_valid;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  initial begin
    logic [55:0] pl;
    logic [7:0]  cs, g;
    logic [31:0] c;
    int unsigned kind;
    reset = 1'b0; in_valid = 1'b0; in_byte = '0;
    idle(3);
    reset = 1'b1;

    ready_mode = 1;
    send_frame(56'h0190_00C8_0203_32, 8'h6A, 0);
    idle(3);
    send_frame(56'h0190_00C8_0203_32, 8'h6B, 0);
    idle(2);
    send_frame(56'h0190_00C8_0203_65, 8'h3D, 0);
    idle(2);

    // Parameter set held for 10 cycles with a SOF offered throughout.
    ready_mode = 2;
    send_frame(56'h1234_5678_0A0B_07, xsum(56'h1234_5678_0A0B_07), 0);
    in_byte = 8'hA5; in_valid = 1'b1;
    idle(10);
    in_valid = 1'b0;
    ready_mode = 1;
    idle(3);

    send_byte(8'h00, c); send_byte(8'hFF, c); send_byte(8'h12, c);
    send_frame(56'h0190_00C8_0203_32, 8'h6A, 1);
    idle(2);

    // Reset after the 4th payload byte; partial frame must vanish.
    send_byte(8'hA5, c);
    send_byte(8'h01, c); send_byte(8'h90, c); send_byte(8'h00, c); send_byte(8'hC8, c);
    reset = 1'b0; err_m = 0;
    idle(3);
    reset = 1'b1;
    send_frame(56'h0064_0032_0102_64, xsum(56'h0064_0032_0102_64), 0);
    idle(2);

    ready_mode = 0;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom % 4;
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h5A;
        send_byte(g, c);
      end
      pl = {16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
            (kind == 3) ? 8'($urandom_range(101, 255)) : 8'($urandom_range(0, 100))};
      cs = xsum(pl);
      if (kind == 2) cs = cs ^ 8'($urandom_range(1, 255));
      send_frame(pl, cs, 2);
    end

    ready_mode = 1;
    idle(5);
    for (int n = 0; n < 260; n++) send_frame(56'h0190_00C8_0203_32, 8'h00, 0);
    idle(3);

`ifdef CCL_TIMEOUT_EN
    reset = 1'b0; err_m = 0;
    idle(2);
    reset = 1'b1;
    send_byte(8'hA5, c);
    send_byte(8'h01, c); send_byte(8'h90, c); send_byte(8'h00, c);
    err_m = 1;
    err_q.push_back('{cnt: 8'd1, cyc: c + 32'd20});
    idle(25);
    send_frame(56'h0190_00C8_0203_32, 8'h6A, 0);
`endif

    idle(20);
    check("param_q_drained", 64'(exp_q.size()), 64'd0);
    check("err_q_drained", 64'(err_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
